// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Holds width helpers, default sizes and the parameter legality check.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 30;
  localparam int DEF_DEPTH  = 16;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit lets the pointers tell a full buffer from an empty one.
  function automatic int ptr_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  function automatic bit params_ok(input int data_w, input int depth,
                                   input int af, input int ae);
    return (data_w >= 1) && (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth);
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// DEPTH x DATA_W storage: one synchronous write port, one asynchronous read.
// Contents are deliberately not reset.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [addr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic [addr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]         rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Parametrised single-clock FIFO with count, threshold flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a 1-cycle registered read.
module sync_fifo_flags
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd,
  output logic [DATA_W-1:0]        data_out,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [ptr_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = addr_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);
  localparam logic [PW-1:0] ONE    = PW'(1);

  if (!params_ok(DATA_W, DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("sync_fifo_flags: illegal parameter combination");
  end

  logic [PW-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] ram_q;

  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty        = (wr_ptr == rd_ptr);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // Acceptance looks only at registered flags, so a full FIFO refuses a write
  // even when a read frees a slot in the same cycle.
  assign wr_ok = wr && !full && !clr;
  assign rd_ok = rd && !empty && !clr;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (wr_ok) wr_ptr_nxt = wr_ptr + ONE;
    if (rd_ok) rd_ptr_nxt = rd_ptr + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_nxt;
      rd_ptr    <= rd_ptr_nxt;
      count     <= wr_ptr_nxt - rd_ptr_nxt;
      overflow  <= wr && full;
      underflow <= rd && empty;
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (ram_q)
  );

`ifdef SYNC_FIFO_FWFT_EN
  assign data_out = empty ? '0 : ram_q;
  assign rd_valid = !empty;
`else
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;

  // ---- stage p1: registered read word and its valid strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
    end else begin
      vld_p1 <= rd_ok;
      if (rd_ok) data_p1 <= ram_q;
    end
  end

  assign data_out = data_p1;
  assign rd_valid = vld_p1;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags (default parameters).
// Data checks adapt to the SYNC_FIFO_FWFT_EN build.
module tb_sync_fifo_flags;

  localparam int DATA_W = 30;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_n, clr, wr, rd;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              rd_valid, full, empty, almost_full, almost_empty;
  logic [4:0]        count;
  logic              overflow, underflow;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] last_rd;

  sync_fifo_flags #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(12), .AE_THRESH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr(wr), .data_in(data_in), .rd(rd),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    wr = 1'b1;
    data_in = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic read_word(input logic [DATA_W-1:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
    check("fwft_head", data_out, exp);
    check("fwft_valid", rd_valid, 1);
    rd = 1'b1;
    tick();
    rd = 1'b0;
`else
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("rd_data", data_out, exp);
    check("rd_valid", rd_valid, 1);
`endif
    last_rd = exp;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0; last_rd = '0;
    repeat (3) tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_aempty", almost_empty, 1);
    check("rst_full", full, 0);
    check("rst_afull", almost_full, 0);
    check("rst_data", data_out, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_unf", underflow, 0);
    rst_n = 1'b1;
    tick();

    // basic ordering
    write_word(512); write_word(2222); write_word(312); write_word(404);
    check("basic_count4", count, 4);
    check("basic_not_empty", empty, 0);
    read_word(512); read_word(2222); read_word(312); read_word(404);
    check("basic_empty", empty, 1);
    check("basic_count0", count, 0);
    tick();
    check("basic_valid_drop", rd_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("basic_hold", data_out, 404);
`endif

    // fill and overflow
    for (int i = 1; i <= 16; i++) begin
      write_word(DATA_W'(i));
      if (i == 15) check("fill_not_full15", full, 0);
    end
    check("fill_full", full, 1);
    check("fill_count16", count, 16);
    check("fill_no_ovf", overflow, 0);
    write_word(17);
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count, 16);
    tick();
    check("ovf_clear", overflow, 0);
    for (int i = 1; i <= 16; i++) read_word(DATA_W'(i));
    check("drain_empty", empty, 1);

    // underflow and thresholds
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("unf_pulse", underflow, 1);
    check("unf_count", count, 0);
    check("unf_no_ovf", overflow, 0);
    tick();
    check("unf_clear", underflow, 0);
    for (int i = 1; i <= 12; i++) begin
      write_word(DATA_W'(100 + i));
      if (i == 3) check("ae_off_at3", almost_empty, 0);
      if (i == 11) check("af_off_at11", almost_full, 0);
    end
    check("af_on_at12", almost_full, 1);
    for (int i = 1; i <= 10; i++) begin
      read_word(DATA_W'(100 + i));
      if (i == 9) check("ae_off_cnt3", almost_empty, 0);
    end
    check("ae_on_cnt2", almost_empty, 1);
    check("ae_count2", count, 2);
    read_word(111); read_word(112);

    // simultaneous wr/rd across pointer wrap
    for (int i = 0; i < 8; i++) write_word(DATA_W'(1000 + i));
    for (int i = 0; i < 40; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
      check("sim_head", data_out, 1000 + i);
`endif
      wr = 1'b1; rd = 1'b1; data_in = DATA_W'(1008 + i);
      tick();
`ifndef SYNC_FIFO_FWFT_EN
      check("sim_data", data_out, 1000 + i);
`endif
      check("sim_count", count, 8);
    end
    wr = 1'b0; rd = 1'b0;
    last_rd = DATA_W'(1039);
    for (int i = 40; i < 48; i++) read_word(DATA_W'(1000 + i));
    check("sim_empty", empty, 1);

    // flush with concurrent write
    for (int i = 0; i < 5; i++) write_word(DATA_W'(50 + i));
    check("clr_pre_count", count, 5);
    clr = 1'b1; wr = 1'b1; data_in = 99;
    tick();
    clr = 1'b0; wr = 1'b0;
    check("clr_count", count, 0);
    check("clr_empty", empty, 1);
    check("clr_no_ovf", overflow, 0);
    check("clr_valid", rd_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
    check("clr_hold_data", data_out, last_rd);
`endif
    tick();
    check("clr_no_ovf2", overflow, 0);

    // asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) write_word(DATA_W'(70 + i));
    check("ar_pre_count", count, 5);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_empty", empty, 1);
    check("ar_count", count, 0);
    check("ar_data", data_out, 0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef SYNC_FIFO_FWFT_EN
    write_word(30'h2A);
    check("fwft_data", data_out, 32'h2A);
    check("fwft_valid_lvl", rd_valid, 1);
    check("fwft_not_empty", empty, 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    check("fwft_pop_empty", empty, 1);
    check("fwft_pop_valid", rd_valid, 0);
`else
    write_word(30'h2A);
    check("std_no_valid_wr", rd_valid, 0);
    read_word(30'h2A);
    tick();
    check("std_valid_once", rd_valid, 0);
    check("std_final_empty", empty, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Parametrised successor to the team's fixed 30-bit synchronous FIFO. Single-clock circular buffer generalised in width and depth, adding an occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow pulses, a synchronous flush and a read-valid strobe. Sits between same-clock producer and consumer blocks as a rate-smoothing buffer.

Parameters:
DATA_W, 30, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=2
AF_THRESH, 12, almost_full asserted when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH (0..DEPTH-1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush, active high
wr  in  1  write request
data_in  in  DATA_W  write data
rd  in  1  read request
data_out  out  DATA_W  read data
rd_valid  out  1  data_out holds a newly read word
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  out  1  one-cycle pulse: write rejected
underflow  out  1  one-cycle pulse: read rejected

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n). Asserting rst_n low at any time, including mid-transfer, immediately clears all state; no partial writes survive.
- Reset values: wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0 (unless AF_THRESH==0, which is illegal), data_out=0, rd_valid=0, overflow=0, underflow=0. Memory contents not reset.
- Pointers are $clog2(DEPTH)+1 bits; address = low bits; full when MSBs differ and address bits match; empty when equal. count = wr_ptr - rd_ptr (modular), registered.
- Write accepted iff wr && !full. Stores data_in at wr_ptr; wr_ptr++ wraps naturally at 2*DEPTH.
- Read accepted iff rd && !empty. rd_ptr++.
- Flags evaluate only registered state: full rejects wr even with simultaneous rd; empty rejects rd even with simultaneous wr.
- Simultaneous accepted wr and rd: count unchanged, both pointers advance.
- Rejected write -> overflow=1 for the following cycle only; rejected read -> underflow=1 for the following cycle only. Never both from the same request.
- Standard mode: on an accepted read, data_out <= mem[rd_ptr] at that edge; rd_valid=1 for exactly that following cycle. data_out holds the last read word otherwise. Read latency: 1 cycle.
- All flags are combinational decodes of registered count and pointers; they change only after a clock edge.
- clr (priority over wr/rd in the same cycle): pointers and count to 0, rd_valid=0, overflow/underflow=0; data_out retains its value. wr/rd in the clr cycle are ignored and do not pulse overflow/underflow.

Optional Feature:
SYNC_FIFO_FWFT_EN: when defined, first-word-fall-through. data_out = mem[rd_ptr] combinationally whenever !empty (0 when empty); rd_valid = !empty (level); rd acknowledges/pops the head. A word written into an empty FIFO is visible on data_out the cycle after the write edge. When undefined: standard 1-cycle registered read as above.

Decomposition:
- Package sync_fifo_pkg: address/count width helper (clog2-based), default DATA_W/DEPTH constants, parameter legality check macro/assertions.
- Sub-module sync_fifo_ram: DEPTH x DATA_W storage, one synchronous write port, one asynchronous read address; the top holds pointers, count, flags and output register.

Test Plan:
- Reset/basic: DATA_W=30, DEPTH=16; write 512,2222,312,404 then read 4 -> data_out 512,2222,312,404 in order, rd_valid pulse each, empty=1 and count=0 at end.
- Fill/overflow: write 17 words 1..17 -> full=1 after 16th, count=16, 17th dropped with overflow pulse; reads return 1..16.
- Underflow/thresholds: rd on empty -> underflow pulse, count stays 0; writing 12 words -> almost_full rises on 12th; reading down to 2 -> almost_empty=1.
- Wrap/simultaneous: 40 cycles of concurrent wr+rd with count at 8 -> count stays 8, data order intact across pointer wrap.
- Flush and reset mid-operation: count=5, pulse clr with wr=1 -> count=0, no overflow; count=5, drop rst_n asynchronously mid-cycle -> empty=1, count=0 immediately.
- FWFT build: write 0x2A into empty FIFO -> next cycle data_out=0x2A, rd_valid=1 without rd; rd pops, empty=1 next cycle.
